// File: rtl/sd_cmd_seq.sv
// SD card SPI-mode command sequencer: frames a 6-byte command with CRC7, drives an
// external spi_master byte by byte, then polls for the R1 response byte.
module sd_cmd_seq #(
   parameter int unsigned RESP_TIMEOUT = 8,
   parameter logic [7:0]  FILL_BYTE    = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        cmd_busy,
   output logic        cmd_done,
   output logic [7:0]  cmd_resp,
   output logic        cmd_timeout,
   output logic        spi_start,
   output logic [7:0]  spi_data_in,
   output logic        sssd_out,
   input  logic [7:0]  spi_data_out,
   input  logic        spi_busy,
   input  logic        spi_new_data
);

   typedef enum logic [2:0] {StIdle, StLoad, StXfer, StWait, StPoll, StDone} state_e;

   localparam logic [7:0] TimeoutCnt = 8'(RESP_TIMEOUT);
   localparam logic [2:0] PollPhase  = 3'd6;

   state_e      state_q, state_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  poll_cnt_q, poll_cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] arg_q, arg_d;
   logic        spi_start_q, spi_start_d;
   logic [7:0]  spi_data_q, spi_data_d;
   logic [7:0]  resp_q, resp_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  frame_byte;
   logic [6:0]  crc;

   function automatic logic [6:0] crc7(input logic [39:0] bits);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = bits[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign crc = crc7({2'b01, idx_q, arg_q});

   always_comb begin
      frame_byte = {crc, 1'b1};
      case (byte_cnt_q)
         3'd0:    frame_byte = {2'b01, idx_q};
         3'd1:    frame_byte = arg_q[31:24];
         3'd2:    frame_byte = arg_q[23:16];
         3'd3:    frame_byte = arg_q[15:8];
         3'd4:    frame_byte = arg_q[7:0];
         default: frame_byte = {crc, 1'b1};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      poll_cnt_d  = poll_cnt_q;
      idx_d       = idx_q;
      arg_d       = arg_q;
      spi_start_d = 1'b0;
      spi_data_d  = spi_data_q;
      resp_d      = resp_q;
      timeout_d   = timeout_q;
      case (state_q)
         StIdle: begin
            if (cmd_start) begin
               idx_d      = cmd_index;
               arg_d      = cmd_arg;
               resp_d     = 8'hFF;
               timeout_d  = 1'b0;
               byte_cnt_d = '0;
               poll_cnt_d = '0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            spi_data_d = frame_byte;
            state_d    = StXfer;
         end
         StXfer: begin
            if (!spi_busy) begin
               spi_start_d = 1'b1;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (spi_new_data) begin
               if (byte_cnt_q < 3'd5) begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  state_d    = StLoad;
               end else if (byte_cnt_q == 3'd5) begin
                  // Received frame-time bytes are discarded; polling starts fresh.
                  byte_cnt_d = PollPhase;
                  poll_cnt_d = '0;
                  state_d    = StPoll;
               end else begin
                  poll_cnt_d = poll_cnt_q + 8'd1;
                  if (!spi_data_out[7]) begin
                     resp_d    = spi_data_out;
                     timeout_d = 1'b0;
                     state_d   = StDone;
                  end else if (poll_cnt_q + 8'd1 >= TimeoutCnt) begin
                     resp_d    = 8'hFF;
                     timeout_d = 1'b1;
                     state_d   = StDone;
                  end else begin
                     state_d = StPoll;
                  end
               end
            end
         end
         StPoll: begin
            spi_data_d = FILL_BYTE;
            state_d    = StXfer;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         byte_cnt_q  <= '0;
         poll_cnt_q  <= '0;
         idx_q       <= '0;
         arg_q       <= '0;
         spi_start_q <= 1'b0;
         spi_data_q  <= '0;
         resp_q      <= 8'hFF;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         poll_cnt_q  <= poll_cnt_d;
         idx_q       <= idx_d;
         arg_q       <= arg_d;
         spi_start_q <= spi_start_d;
         spi_data_q  <= spi_data_d;
         resp_q      <= resp_d;
         timeout_q   <= timeout_d;
      end
   end

   assign cmd_busy    = (state_q != StIdle);
   assign cmd_done    = (state_q == StDone);
   assign sssd_out    = (state_q == StIdle) || (state_q == StDone);
   assign cmd_resp    = resp_q;
   assign cmd_timeout = timeout_q;
   assign spi_start   = spi_start_q;
   assign spi_data_in = spi_data_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Self-checking bench for sd_cmd_seq: behavioural SPI byte-master model, directed command
// table, reset/busy/re-trigger corner cases and randomized commands against a reference model.
module tb_sd_cmd_seq;

   localparam int unsigned RespTimeout = 8;
   localparam logic [7:0]  Fill        = 8'hFF;

   logic        clk, rst;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_busy, cmd_done, cmd_timeout;
   logic [7:0]  cmd_resp;
   logic        spi_start, sssd_out;
   logic [7:0]  spi_data_in, spi_data_out;
   logic        spi_busy, spi_new_data;

   int tests = 0;
   int fails = 0;

   logic [7:0] rx_q[$];
   logic [7:0] poll_q[$];
   logic [7:0] tx_log[$];
   int         model_err;
   int         xfer_len   = 2;
   int         hold_after = 0;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  crc;
      int          nff;
      logic [7:0]  resp;
   } vec_t;

   vec_t vecs[6];

   sd_cmd_seq #(.RESP_TIMEOUT(RespTimeout), .FILL_BYTE(Fill)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_start    (cmd_start),
      .cmd_index    (cmd_index),
      .cmd_arg      (cmd_arg),
      .cmd_busy     (cmd_busy),
      .cmd_done     (cmd_done),
      .cmd_resp     (cmd_resp),
      .cmd_timeout  (cmd_timeout),
      .spi_start    (spi_start),
      .spi_data_in  (spi_data_in),
      .sssd_out     (sssd_out),
      .spi_data_out (spi_data_out),
      .spi_busy     (spi_busy),
      .spi_new_data (spi_new_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // SPI byte master: busy for xfer_len cycles after spi_start, then one new_data strobe.
   initial begin
      int         mst, cnt, hcnt;
      logic [7:0] cur_tx;
      mst = 0; cnt = 0; hcnt = 0; cur_tx = '0;
      spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'hFF;
      forever begin
         @(negedge clk);
         spi_new_data = 1'b0;
         if (rst) begin
            mst = 0;
            spi_busy = 1'b0;
            continue;
         end
         case (mst)
            0: if (spi_start) begin
                  cur_tx = spi_data_in;
                  tx_log.push_back(cur_tx);
                  cnt = xfer_len;
                  spi_busy = 1'b1;
                  mst = 1;
               end
            1: begin
                  if (spi_start) model_err++;
                  if (spi_data_in !== cur_tx) model_err++;
                  cnt--;
                  if (cnt == 0) begin
                     spi_data_out = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                     spi_new_data = 1'b1;
                     hcnt = hold_after;
                     spi_busy = (hold_after > 0);
                     mst = (hold_after > 0) ? 2 : 0;
                  end
               end
            default: begin
                  if (spi_start) model_err++;
                  hcnt--;
                  if (hcnt == 0) begin
                     spi_busy = 1'b0;
                     mst = 0;
                  end
               end
         endcase
      end
   end

   // CRC7 by polynomial long division of the 40 frame bits times x^7.
   function automatic logic [7:0] ref_crc_byte(input logic [5:0] idx, input logic [31:0] arg);
      logic [46:0] r;
      r = {2'b01, idx, arg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r = r ^ (47'h89 << (i - 7));
      return {r[6:0], 1'b1};
   endfunction

   task automatic load_rx(input int nff, input logic [7:0] resp, input logic junk_low);
      rx_q.delete();
      poll_q.delete();
      for (int i = 0; i < 6; i++)
         rx_q.push_back(junk_low ? 8'($urandom_range(0, 127)) : 8'hFF);
      for (int i = 0; i < nff; i++) poll_q.push_back(8'h80 | 8'($urandom));
      poll_q.push_back(resp);
      foreach (poll_q[i]) rx_q.push_back(poll_q[i]);
   endtask

   task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic mid_start);
      logic [7:0] exp_tx[$];
      logic [7:0] exp_resp, got_resp;
      logic       exp_to, got_to, got_done, mid_fired;
      int         npoll, lat, n, done_cnt, busy_err;
      // Reference: first poll byte with bit7 clear inside the timeout window wins.
      exp_resp = 8'hFF; exp_to = 1'b1; npoll = RespTimeout;
      for (int i = 0; i < int'(RespTimeout); i++) begin
         if (i < poll_q.size() && !poll_q[i][7]) begin
            exp_resp = poll_q[i]; exp_to = 1'b0; npoll = i + 1;
            break;
         end
      end
      exp_tx = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0],
                 ref_crc_byte(idx, arg)};
      for (int i = 0; i < npoll; i++) exp_tx.push_back(Fill);

      tx_log.delete();
      model_err = 0;
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
      n = 1; lat = -1; done_cnt = 0; busy_err = 0; got_done = 1'b0; mid_fired = 1'b0;
      got_resp = '0; got_to = 1'b0;
      while (!got_done && n < 4000) begin
         if (spi_start && lat < 0) lat = n;
         if (!cmd_busy) busy_err++;
         if (!cmd_done && sssd_out) busy_err++;
         if (cmd_done) begin
            got_done = 1'b1; done_cnt++; got_resp = cmd_resp; got_to = cmd_timeout;
         end
         if (mid_start && !mid_fired && tx_log.size() == 3) begin
            cmd_start = 1'b1; cmd_index = 6'h3F; cmd_arg = 32'hFFFF_FFFF; mid_fired = 1'b1;
         end else begin
            cmd_start = 1'b0;
         end
         if (!got_done) begin
            @(negedge clk);
            n++;
         end
      end
      check({tag, " done_seen"}, 32'(got_done), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (cmd_done) done_cnt++;
      end
      check({tag, " latency"}, 32'(lat), 32'd3);
      check({tag, " done_count"}, 32'(done_cnt), 32'd1);
      check({tag, " busy_cs_during"}, 32'(busy_err), 32'd0);
      check({tag, " resp"}, 32'(got_resp), 32'(exp_resp));
      check({tag, " timeout"}, 32'(got_to), 32'(exp_to));
      check({tag, " tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
         check($sformatf("%s tx[%0d]", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
      check({tag, " spi_protocol"}, 32'(model_err), 32'd0);
      check({tag, " idle_busy"}, 32'(cmd_busy), 32'd0);
      check({tag, " idle_cs"}, 32'(sssd_out), 32'd1);
      check({tag, " resp_held"}, 32'(cmd_resp), 32'(exp_resp));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, 32'(cmd_busy), 32'd0);
      check({tag, " done"}, 32'(cmd_done), 32'd0);
      check({tag, " resp"}, 32'(cmd_resp), 32'hFF);
      check({tag, " timeout"}, 32'(cmd_timeout), 32'd0);
      check({tag, " spi_start"}, 32'(spi_start), 32'd0);
      check({tag, " spi_data_in"}, 32'(spi_data_in), 32'd0);
      check({tag, " cs"}, 32'(sssd_out), 32'd1);
   endtask

   initial begin
      int done_cnt, n;
      vecs[0] = '{6'd0,  32'h0000_0000, 8'h95, 1, 8'h01};
      vecs[1] = '{6'd8,  32'h0000_01AA, 8'h87, 0, 8'h01};
      vecs[2] = '{6'd55, 32'h0000_0000, 8'h65, 2, 8'h01};
      vecs[3] = '{6'd41, 32'h4000_0000, 8'h77, 3, 8'h00};
      vecs[4] = '{6'd58, 32'h0000_0000, 8'hFD, 7, 8'h00};
      vecs[5] = '{6'd17, 32'h0000_0000, 8'h55, 8, 8'h00};

      rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      foreach (vecs[v]) begin
         load_rx(vecs[v].nff, vecs[v].resp, 1'b1);
         run_cmd($sformatf("vec%0d", v), vecs[v].idx, vecs[v].arg, 1'b0);
         if (tx_log.size() >= 6)
            check($sformatf("vec%0d crc_const", v), 32'(tx_log[5]), 32'(vecs[v].crc));
      end

      // Re-trigger during frame byte 3 must not disturb the command in flight.
      xfer_len = 3;
      load_rx(0, 8'h01, 1'b0);
      run_cmd("mid_start", 6'd8, 32'h0000_01AA, 1'b1);

      // Master stays busy 5 cycles after each byte; spi_start must wait.
      xfer_len = 1; hold_after = 5;
      load_rx(1, 8'h01, 1'b0);
      run_cmd("hold_busy", 6'd0, 32'h0, 1'b0);
      hold_after = 0; xfer_len = 2;

      // Reset during poll byte 2 abandons the command silently.
      load_rx(20, 8'h00, 1'b0);
      tx_log.delete();
      @(negedge clk);
      cmd_index = 6'd0; cmd_arg = '0; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      n = 0;
      while (tx_log.size() < 8 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_poll2 reached", 32'(tx_log.size() >= 8), 32'd1);
      #1 rst = 1'b1;
      #1 check_reset_vals("rst_mid");
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (cmd_done) done_cnt++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (cmd_done) done_cnt++;
      end
      check("rst_mid no_done", 32'(done_cnt), 32'd0);
      load_rx(1, 8'h01, 1'b0);
      run_cmd("after_rst", 6'd0, 32'h0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         xfer_len   = $urandom_range(1, 3);
         hold_after = $urandom_range(0, 2);
         load_rx($urandom_range(0, 10), 8'($urandom_range(0, 127)), 1'b1);
         run_cmd($sformatf("rnd%0d", k), 6'($urandom), $urandom, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
